// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module : freq_meter_pkg
// Brief  : Shared state encoding and default counter width for the meter.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package freq_meter_pkg;

  localparam int c_cntWDefault = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    GATE  = 3'd2,
    CLOSE = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/freq_gate_sequencer_edge_sync.sv
// ============================================================================
// Module : edge_sync
// Brief  : Multi-flop synchronizer with a one-cycle rising-edge pulse output.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysClk,
  input  logic sysRst,
  input  logic signal,
  output logic edgePulse
);

  // Depths below two give no metastability protection, so clamp.
  localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [c_stages-1:0] r_sync;
  logic                r_prev;

  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[c_stages-2:0], signal};
      r_prev <= r_sync[c_stages-1];
    end
  end

  assign edgePulse = r_sync[c_stages-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/freq_gate_sequencer.sv
// ============================================================================
// Module : freq_gate_sequencer
// Brief  : Gated reciprocal frequency meter: edge-aligned gate, result handshake.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module freq_gate_sequencer
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = c_cntWDefault,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sysClk,
  input  logic             sysRst,
  input  logic             signal,
  input  logic             start,
  input  logic             continuous,
  input  logic [CNT_W-1:0] gateLen,
  output logic             busy,
  output logic             resValid,
  input  logic             resReady,
  output logic [CNT_W-1:0] refCount,
  output logic [CNT_W-1:0] sigCount,
  output logic             timeout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] c_ones = '1;

  state_t           r_state, w_nextState;
  logic [CNT_W-1:0] r_gLen, r_refBuf, r_sigBuf, r_waitCnt;
  logic [CNT_W-1:0] r_refCount, r_sigCount;
  logic             r_timeout, r_overflow, r_ovfAcc;

  logic             w_edge;
  logic [CNT_W-1:0] w_refInc, w_sigInc, w_waitInc, w_gLenNew;
  logic             w_refSat, w_sigSat;
  logic [CNT_W:0]   w_refPlus2;
  logic             w_armExpire, w_gateDone, w_closeExpire, w_arm;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edgeSync (
    .sysClk    (sysClk),
    .sysRst    (sysRst),
    .signal    (signal),
    .edgePulse (w_edge)
  );

  assign w_refSat  = (r_refBuf == c_ones);
  assign w_sigSat  = (r_sigBuf == c_ones);
  assign w_refInc  = w_refSat ? r_refBuf : r_refBuf + 1'b1;
  assign w_sigInc  = w_sigSat ? r_sigBuf : r_sigBuf + 1'b1;
  assign w_waitInc = r_waitCnt + 1'b1;
  assign w_gLenNew = (gateLen == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : gateLen;

  // Enter CLOSE one cycle early so an edge landing on count gLen can close the gate.
  assign w_refPlus2    = {1'b0, r_refBuf} + (CNT_W+1)'(2);
  assign w_gateDone    = (w_refPlus2 >= {1'b0, r_gLen});
  assign w_closeExpire = ({1'b0, w_refInc} >= {r_gLen, 1'b0});
  assign w_armExpire   = (w_waitInc == r_gLen);
  assign w_arm         = ((r_state == IDLE) && start) ||
                         ((r_state == HOLD) && resReady && continuous);

  always_ff @(posedge sysClk) begin
    if (sysRst) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (start) w_nextState = ARM;
      ARM: begin
        if (w_edge)           w_nextState = GATE;
        else if (w_armExpire) w_nextState = HOLD;
      end
      GATE:  if (w_gateDone) w_nextState = CLOSE;
      CLOSE: if (w_edge || w_closeExpire) w_nextState = HOLD;
      HOLD:  if (resReady) w_nextState = continuous ? ARM : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != IDLE);
    resValid = (r_state == HOLD);
  end

  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      r_gLen     <= '0;
      r_refBuf   <= '0;
      r_sigBuf   <= '0;
      r_waitCnt  <= '0;
      r_refCount <= '0;
      r_sigCount <= '0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
      r_ovfAcc   <= 1'b0;
    end else if (w_arm) begin
      r_gLen     <= w_gLenNew;
      r_refBuf   <= '0;
      r_sigBuf   <= '0;
      r_waitCnt  <= '0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
      r_ovfAcc   <= 1'b0;
    end else begin
      case (r_state)
        ARM: begin
          if (w_edge) begin
            r_refBuf <= '0;
            r_sigBuf <= '0;
          end else begin
            r_waitCnt <= w_waitInc;
            if (w_armExpire) begin
              r_refCount <= r_gLen;
              r_sigCount <= '0;
              r_timeout  <= 1'b1;
              r_overflow <= r_ovfAcc;
            end
          end
        end
        GATE: begin
          r_refBuf <= w_refInc;
          if (w_edge) r_sigBuf <= w_sigInc;
          r_ovfAcc <= r_ovfAcc | w_refSat | (w_edge & w_sigSat);
        end
        CLOSE: begin
          r_refBuf <= w_refInc;
          r_ovfAcc <= r_ovfAcc | w_refSat;
          if (w_edge) begin
            r_refCount <= w_refInc;
            r_sigCount <= w_sigInc;
            r_timeout  <= 1'b0;
            r_overflow <= r_ovfAcc | w_refSat | w_sigSat;
          end else if (w_closeExpire) begin
            r_refCount <= w_refInc;
            r_sigCount <= '0;
            r_timeout  <= 1'b1;
            r_overflow <= r_ovfAcc | w_refSat;
          end
        end
        default: ;
      endcase
    end
  end

  assign refCount = r_refCount;
  assign sigCount = r_sigCount;
  assign timeout  = r_timeout;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_freq_gate_sequencer.sv
// ============================================================================
// Module : tb_freq_gate_sequencer
// Brief  : Directed self-checking bench for the gated frequency meter.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_freq_gate_sequencer;

  localparam int W = 8;

  logic         sysClk = 1'b0;
  logic         sysRst = 1'b1;
  logic         signal = 1'b0;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         resReady = 1'b0;
  logic [W-1:0] gateLen = '0;
  logic         busy, resValid, timeout, overflow;
  logic [W-1:0] refCount, sigCount;

  logic [31:0]  gateLen32;
  logic         busy32, resValid32, timeout32, overflow32;
  logic [31:0]  refCount32, sigCount32;

  int           passCnt = 0;
  int           failCnt = 0;
  int           totalCnt = 0;
  int           sigPeriod = 0;
  logic         manualSig = 1'b0;
  int           genPhase = 0;
  int           n;
  int           seenValid;
  logic [W-1:0] holdRef, holdSig;

  assign gateLen32 = {24'd0, gateLen};

  freq_gate_sequencer #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .sysClk(sysClk), .sysRst(sysRst), .signal(signal), .start(start),
    .continuous(continuous), .gateLen(gateLen), .busy(busy),
    .resValid(resValid), .resReady(resReady), .refCount(refCount),
    .sigCount(sigCount), .timeout(timeout), .overflow(overflow)
  );

  freq_gate_sequencer dut32 (
    .sysClk(sysClk), .sysRst(sysRst), .signal(signal), .start(start),
    .continuous(continuous), .gateLen(gateLen32), .busy(busy32),
    .resValid(resValid32), .resReady(resReady), .refCount(refCount32),
    .sigCount(sigCount32), .timeout(timeout32), .overflow(overflow32)
  );

  always #5 sysClk = ~sysClk;

  // Periodic square wave (high for period/2 cycles) or a manually held level.
  initial begin
    forever begin
      @(posedge sysClk);
      #2;
      if (sigPeriod > 0) begin
        signal   = (genPhase < sigPeriod / 2);
        genPhase = (genPhase + 1 >= sigPeriod) ? 0 : genPhase + 1;
      end else begin
        signal   = manualSig;
        genPhase = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic startMeas(input logic [W-1:0] len);
    gateLen = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic waitValid(input int maxCycles, input string tag, output int cycles);
    cycles = 0;
    while (!resValid && cycles < maxCycles) begin
      tick();
      cycles++;
    end
    check(tag, resValid, 1);
  endtask

  task automatic handshake();
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", resValid, 0);
    check("rst_ref", refCount, 0);
    check("rst_sig", sigCount, 0);
    check("rst_flags", {timeout, overflow}, 0);
    sysRst = 1'b0;
    tick();

    // Period 10, gate 100: ten whole periods.
    sigPeriod = 10;
    startMeas(8'd100);
    repeat (20) tick();
    startMeas(8'd5);
    waitValid(400, "a_wait", n);
    check("a_ref", refCount, 100);
    check("a_sig", sigCount, 10);
    check("a_flags", {timeout, overflow}, 0);
    check("a_busy_hold", busy, 1);
    check("a_ref32", refCount32, 100);
    check("a_sig32", sigCount32, 10);
    handshake();
    check("a_idle", {busy, resValid}, 0);

    // Period 7, gate 50: first period multiple at or beyond 50 is 56.
    sigPeriod = 7;
    startMeas(8'd50);
    waitValid(300, "b_wait", n);
    check("b_ref", refCount, 56);
    check("b_sig", sigCount, 8);
    check("b_timeout", timeout, 0);
    handshake();

    // No signal: timeout after exactly gateLen ARM cycles.
    sigPeriod = 0;
    manualSig = 1'b0;
    repeat (6) tick();
    startMeas(8'd20);
    waitValid(100, "c_wait", n);
    check("c_latency", n, 20);
    check("c_ref", refCount, 20);
    check("c_sig", sigCount, 0);
    check("c_timeout", timeout, 1);
    handshake();

    // gateLen of zero behaves as one.
    startMeas(8'd0);
    waitValid(20, "z_wait", n);
    check("z_latency", n, 1);
    check("z_ref", refCount, 1);
    check("z_timeout", timeout, 1);
    handshake();

    // Continuous mode with back-pressure.
    sigPeriod  = 10;
    continuous = 1'b1;
    startMeas(8'd100);
    waitValid(400, "d_wait", n);
    check("d_ref", refCount, 100);
    check("d_sig", sigCount, 10);
    holdRef = refCount;
    holdSig = sigCount;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("d_stable", {resValid, refCount, sigCount, timeout, overflow},
            {1'b1, 8'd100, 8'd10, 1'b0, 1'b0});
    end
    handshake();
    continuous = 1'b0;
    check("d_rearm", {busy, resValid}, 2'b10);
    waitValid(400, "d_wait2", n);
    check("d_ref2", refCount, holdRef);
    check("d_sig2", sigCount, holdSig);
    handshake();
    check("d_idle", busy, 0);

    // Reset mid-gate discards the measurement.
    startMeas(8'd100);
    repeat (50) tick();
    sysRst = 1'b1;
    tick();
    tick();
    check("e_rst_state", {busy, resValid}, 0);
    check("e_rst_ref", refCount, 0);
    check("e_rst_sig", sigCount, 0);
    sysRst = 1'b0;
    seenValid = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (resValid) seenValid++;
    end
    check("e_no_stale", seenValid, 0);
    startMeas(8'd100);
    waitValid(400, "e_wait", n);
    check("e_ref", refCount, 100);
    check("e_sig", sigCount, 10);
    sysRst = 1'b1;
    tick();
    check("e_rst_hold", {busy, resValid}, 0);
    sysRst = 1'b0;
    tick();
    check("e_after_hold", resValid, 0);

    // Period 2, gate 127 with 8-bit counters: no saturation.
    sigPeriod = 2;
    startMeas(8'd127);
    waitValid(400, "f_wait", n);
    check("f_ref", refCount, 128);
    check("f_sig", sigCount, 64);
    check("f_ovf", overflow, 0);
    handshake();

    // Long silence in CLOSE saturates refBuf at 255.
    sigPeriod = 0;
    manualSig = 1'b0;
    repeat (6) tick();
    startMeas(8'd250);
    repeat (3) tick();
    manualSig = 1'b1;
    repeat (4) tick();
    manualSig = 1'b0;
    repeat (300) tick();
    check("g_open", {busy, resValid}, 2'b10);
    manualSig = 1'b1;
    waitValid(20, "g_wait", n);
    check("g_ref", refCount, 255);
    check("g_sig", sigCount, 1);
    check("g_ovf", overflow, 1);
    check("g_timeout", timeout, 0);
    handshake();
    manualSig = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

`default_nettype wire
